// File: rtl/keystone_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keystone_pkg : shared types and constants for the keystone frame controller
// Revision     : 1.0
// ----------------------------------------------------------------------------
package keystone_pkg;

    typedef enum logic [1:0] {
        FLUSH    = 2'd0,
        IDLE     = 2'd1,
        WAIT_SOF = 2'd2,
        ACTIVE   = 2'd3
    } state_t;

    typedef logic [31:0] coef_t;

    localparam int         NUM_COEF_DEFAULT = 8;
    localparam logic [3:0] CFG_ADDR_LPF     = 4'(NUM_COEF_DEFAULT);

    // A programmed frame length of zero behaves as a one-line frame.
    function automatic logic [15:0] lpf_effective(input logic [15:0] lpf);
        return (lpf == 16'd0) ? 16'd1 : lpf;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keystone_cfg_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keystone_cfg_bank : staging/active coefficient and lines-per-frame registers
// Revision          : 1.0
// ----------------------------------------------------------------------------
module keystone_cfg_bank
    import keystone_pkg::*;
#(
    parameter int         NUM_COEF = NUM_COEF_DEFAULT,
    parameter logic [3:0] LPF_ADDR = CFG_ADDR_LPF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aclken,
    input  logic                  cfg_wr,
    input  logic [3:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    input  logic                  load,
    output logic [NUM_COEF*32-1:0] coef_active,
    output logic [15:0]           lpf_active
);

    logic [15:0] r_lpf_staging;
    logic [15:0] r_lpf_active;

    // A load samples staging before any same-cycle write lands there.
    generate
        for (genvar i = 0; i < NUM_COEF; i++) begin : g_coef
            coef_t r_staging;
            coef_t r_active;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_staging <= '0;
                    r_active  <= '0;
                end else if (aclken) begin
                    if (cfg_wr && (cfg_addr == 4'(i))) begin
                        r_staging <= cfg_wdata;
                    end
                    if (load) begin
                        r_active <= r_staging;
                    end
                end
            end

            assign coef_active[i*32 +: 32] = r_active;
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lpf_staging <= 16'd1;
            r_lpf_active  <= 16'd1;
        end else if (aclken) begin
            if (cfg_wr && (cfg_addr == LPF_ADDR)) begin
                r_lpf_staging <= cfg_wdata[15:0];
            end
            if (load) begin
                r_lpf_active <= r_lpf_staging;
            end
        end
    end

    assign lpf_active = r_lpf_active;

endmodule
`default_nettype wire

// File: rtl/keystone_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keystone_frame_ctrl : frame sequencing, flush and bank control for the core
// Revision            : 1.0
// ----------------------------------------------------------------------------
module keystone_frame_ctrl
    import keystone_pkg::*;
#(
    parameter int NUM_COEF   = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   aclken,
    input  logic                   sw_en,
    input  logic                   sw_rst,
    input  logic                   cfg_wr,
    input  logic [3:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tuser,
    input  logic                   mon_tlast,
    output logic                   core_clock_en,
    output logic                   core_reset,
    output logic [NUM_COEF*32-1:0] coef_active,
    output logic [15:0]            frame_count,
    output logic [15:0]            line_count,
    output logic                   busy,
    output logic                   sof_err
);

    localparam int             FCW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(RST_CYCLES - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [FCW-1:0] r_flush_cnt;
    logic [FCW-1:0] w_flush_cnt_next;
    logic           r_mid_line;
    logic           w_mid_line_next;
    logic [15:0]    r_line_count;
    logic [15:0]    w_line_next;
    logic [15:0]    r_frame_count;
    logic [15:0]    w_frame_next;
    logic           r_sof_err;
    logic           w_sof_err_next;
    logic           r_core_reset;
    logic           r_busy;
    logic           w_load;
    logic           w_beat;
    logic           w_sof_seen;
    logic           w_last_line;
    logic [15:0]    w_lpf_active;

    assign w_beat      = mon_tvalid & mon_tready;
    assign w_sof_seen  = mon_tvalid & mon_tuser;
    assign w_last_line = (r_line_count == (lpf_effective(w_lpf_active) - 16'd1));

    keystone_cfg_bank #(
        .NUM_COEF (NUM_COEF),
        .LPF_ADDR (4'(NUM_COEF))
    ) u_cfg_bank (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .aclken      (aclken),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .load        (w_load),
        .coef_active (coef_active),
        .lpf_active  (w_lpf_active)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= FLUSH;
            r_flush_cnt   <= '0;
            r_mid_line    <= 1'b0;
            r_line_count  <= 16'd0;
            r_frame_count <= 16'd0;
            r_sof_err     <= 1'b0;
            r_core_reset  <= 1'b1;
            r_busy        <= 1'b0;
        end else if (aclken) begin
            r_state       <= w_state_next;
            r_flush_cnt   <= w_flush_cnt_next;
            r_mid_line    <= w_mid_line_next;
            r_line_count  <= w_line_next;
            r_frame_count <= w_frame_next;
            r_sof_err     <= w_sof_err_next;
            r_core_reset  <= (w_state_next == FLUSH);
            r_busy        <= (w_state_next == ACTIVE);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_mid_line_next  = r_mid_line;
        w_line_next      = r_line_count;
        w_frame_next     = r_frame_count;
        w_sof_err_next   = r_sof_err;
        w_load           = 1'b0;

        if (sw_rst) begin
            w_state_next     = FLUSH;
            w_flush_cnt_next = '0;
            w_mid_line_next  = 1'b0;
            w_line_next      = 16'd0;
            w_sof_err_next   = 1'b0;
        end else begin
            case (r_state)
                FLUSH: begin
                    w_mid_line_next = 1'b0;
                    w_line_next     = 16'd0;
                    w_sof_err_next  = 1'b0;
                    if (r_flush_cnt == FLUSH_LAST) begin
                        w_state_next     = IDLE;
                        w_flush_cnt_next = '0;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (sw_en) begin
                        w_state_next = WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (!sw_en) begin
                        w_state_next = IDLE;
                    end else if (w_sof_seen) begin
                        w_load          = aclken;
                        w_line_next     = 16'd0;
                        w_mid_line_next = w_beat & ~mon_tlast;
                        w_state_next    = ACTIVE;
                    end
                end
                ACTIVE: begin
                    // An early SOF restarts the frame on the new bank.
                    if (w_sof_seen && ((r_line_count != 16'd0) || r_mid_line)) begin
                        w_sof_err_next  = 1'b1;
                        w_load          = aclken;
                        w_line_next     = 16'd0;
                        w_mid_line_next = w_beat & ~mon_tlast;
                    end else if (w_beat) begin
                        if (mon_tlast) begin
                            w_mid_line_next = 1'b0;
                            if (w_last_line) begin
                                w_line_next  = 16'd0;
                                w_frame_next = r_frame_count + 16'd1;
                                w_state_next = sw_en ? WAIT_SOF : IDLE;
                            end else begin
                                w_line_next = r_line_count + 16'd1;
                            end
                        end else begin
                            w_mid_line_next = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = FLUSH;
                end
            endcase
        end
    end

    assign core_clock_en = (r_state == ACTIVE) & aclken;
    assign core_reset    = r_core_reset;
    assign busy          = r_busy;
    assign sof_err       = r_sof_err;
    assign line_count    = r_line_count;
    assign frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_keystone_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_keystone_frame_ctrl : self-checking bench for keystone_frame_ctrl
// Revision               : 1.0
// ----------------------------------------------------------------------------
module tb_keystone_frame_ctrl;

    localparam int NC = 8;

    logic            aclk;
    logic            aresetn;
    logic            aclken;
    logic            sw_en;
    logic            sw_rst;
    logic            cfg_wr;
    logic [3:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic            mon_tvalid;
    logic            mon_tready;
    logic            mon_tuser;
    logic            mon_tlast;
    logic            core_clock_en;
    logic            core_reset;
    logic [NC*32-1:0] coef_active;
    logic [15:0]     frame_count;
    logic [15:0]     line_count;
    logic            busy;
    logic            sof_err;

    keystone_frame_ctrl #(.NUM_COEF(NC), .RST_CYCLES(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .aclken        (aclken),
        .sw_en         (sw_en),
        .sw_rst        (sw_rst),
        .cfg_wr        (cfg_wr),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .mon_tuser     (mon_tuser),
        .mon_tlast     (mon_tlast),
        .core_clock_en (core_clock_en),
        .core_reset    (core_reset),
        .coef_active   (coef_active),
        .frame_count   (frame_count),
        .line_count    (line_count),
        .busy          (busy),
        .sof_err       (sof_err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // Fields: sw_en sw_rst aclken sof | core_reset busy core_clock_en
    typedef struct packed {
        logic sw_en;
        logic sw_rst;
        logic aclken;
        logic sof;
        logic exp_cr;
        logic exp_busy;
        logic exp_cce;
    } vec_t;

    typedef struct {
        logic [15:0] line;
        logic [15:0] frame;
        logic        busy;
        logic        err;
    } exp_t;

    vec_t        vecs [18];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_line;
    logic [15:0] m_frame;
    logic [15:0] m_lpf;
    logic        m_act;
    logic        m_mid;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic mon_idle();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tuser  = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_wr    = 1'b0;
    endtask

    // One accepted beat; the expectation is queued before the edge and
    // compared once the DUT has responded to it.
    task automatic drive_beat(input logic tuser, input logic tlast, input logic wr,
                              input logic [3:0] addr, input logic [31:0] data);
        exp_t e;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = tuser;
        mon_tlast  = tlast;
        cfg_wr     = wr;
        cfg_addr   = addr;
        cfg_wdata  = data;
        if (!m_act) begin
            if (tuser) begin
                m_act  = 1'b1;
                m_line = 16'd0;
                m_mid  = ~tlast;
            end
        end else if (tuser && ((m_line != 16'd0) || m_mid)) begin
            m_err  = 1'b1;
            m_line = 16'd0;
            m_mid  = ~tlast;
        end else if (tlast) begin
            m_mid = 1'b0;
            if (m_line == m_lpf - 16'd1) begin
                m_line  = 16'd0;
                m_frame = m_frame + 16'd1;
                m_act   = 1'b0;
            end else begin
                m_line = m_line + 16'd1;
            end
        end else begin
            m_mid = 1'b1;
        end
        e.line  = m_line;
        e.frame = m_frame;
        e.busy  = m_act;
        e.err   = m_err;
        sb.push_back(e);
        tick();
        mon_idle();
        cfg_wr = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("line_count", {16'd0, line_count}, {16'd0, e.line});
            chk("frame_count", {16'd0, frame_count}, {16'd0, e.frame});
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
            chk("sof_err", {31'd0, sof_err}, {31'd0, e.err});
            chk("core_clock_en", {31'd0, core_clock_en}, {31'd0, e.busy});
        end
    endtask

    task automatic line_tail(input int from_beat);
        for (int b = from_beat; b < 8; b++) begin
            drive_beat(1'b0, (b == 7), 1'b0, 4'd0, 32'd0);
        end
    endtask

    task automatic chk_coef(input int k, input logic [31:0] req);
        chk($sformatf("coef_active[%0d]", k), coef_active[k*32 +: 32], req);
    endtask

    initial begin
        int cr_cycles;

        aresetn   = 1'b0;
        aclken    = 1'b1;
        sw_en     = 1'b0;
        sw_rst    = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = 4'd0;
        cfg_wdata = 32'd0;
        mon_idle();
        m_line  = 16'd0;
        m_frame = 16'd0;
        m_lpf   = 16'd1;
        m_act   = 1'b0;
        m_mid   = 1'b0;
        m_err   = 1'b0;

        vecs[0]  = {4'b0010, 3'b100};
        vecs[1]  = {4'b0010, 3'b100};
        vecs[2]  = {4'b0010, 3'b100};
        vecs[3]  = {4'b0010, 3'b000};
        vecs[4]  = {4'b0011, 3'b000};
        vecs[5]  = {4'b1010, 3'b000};
        vecs[6]  = {4'b0011, 3'b000};
        vecs[7]  = {4'b1011, 3'b000};
        vecs[8]  = {4'b1001, 3'b000};
        vecs[9]  = {4'b1011, 3'b011};
        vecs[10] = {4'b1000, 3'b010};
        vecs[11] = {4'b1110, 3'b100};
        vecs[12] = {4'b1110, 3'b100};
        vecs[13] = {4'b0010, 3'b100};
        vecs[14] = {4'b0000, 3'b100};
        vecs[15] = {4'b0010, 3'b100};
        vecs[16] = {4'b0010, 3'b100};
        vecs[17] = {4'b0010, 3'b000};

        tick();
        tick();
        tick();
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_core_clock_en", {31'd0, core_clock_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sof_err", {31'd0, sof_err}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_line_count", {16'd0, line_count}, 32'd0);
        for (int k = 0; k < NC; k++) chk_coef(k, 32'd0);
        aresetn = 1'b1;

        // Flush after reset, IDLE/WAIT_SOF handshake, clock-enable hold, sw_rst.
        for (int i = 0; i < 18; i++) begin
            sw_en      = vecs[i].sw_en;
            sw_rst     = vecs[i].sw_rst;
            aclken     = vecs[i].aclken;
            mon_tvalid = vecs[i].sof;
            mon_tuser  = vecs[i].sof;
            tick();
            chk($sformatf("vec%0d_core_reset", i), {31'd0, core_reset}, {31'd0, vecs[i].exp_cr});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_core_clock_en", i), {31'd0, core_clock_en}, {31'd0, vecs[i].exp_cce});
        end
        mon_idle();
        sw_en  = 1'b0;
        sw_rst = 1'b0;
        aclken = 1'b1;

        // Frame 1: three lines of eight beats.
        for (int k = 0; k < NC; k++) cfg_write(4'(k), 32'hC0DE0000 | 32'(k));
        cfg_write(4'd8, 32'hDEAD0003);
        cfg_write(4'd9, 32'h00000005);
        cfg_write(4'd15, 32'hFFFFFFFF);
        m_lpf = 16'd3;
        sw_en = 1'b1;
        tick();
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < NC; k++) chk_coef(k, 32'hC0DE0000 | 32'(k));
        line_tail(1);
        line_tail(0);
        line_tail(0);
        chk("frame1_count", {16'd0, frame_count}, 32'd1);

        // Frame 2: coefficient write coincides with the SOF load.
        drive_beat(1'b1, 1'b0, 1'b1, 4'd2, 32'hA5A5A5A5);
        chk_coef(2, 32'hC0DE0002);
        line_tail(1);
        line_tail(0);
        line_tail(0);

        // Frame 3: new value appears; clock enable dropped mid-line.
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        chk_coef(2, 32'hA5A5A5A5);
        drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        aclken     = 1'b0;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("frz_core_clock_en", {31'd0, core_clock_en}, 32'd0);
            chk("frz_line_count", {16'd0, line_count}, {16'd0, m_line});
            chk("frz_frame_count", {16'd0, frame_count}, {16'd0, m_frame});
        end
        mon_idle();
        aclken = 1'b1;
        line_tail(3);
        line_tail(0);
        line_tail(0);

        // Frame 4: early SOF at line 1 beat 3 reloads the bank.
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        line_tail(1);
        cfg_write(4'd0, 32'h0BADF00D);
        for (int b = 0; b < 3; b++) drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        chk_coef(0, 32'h0BADF00D);
        line_tail(1);
        line_tail(0);
        line_tail(0);

        // Frame 5: software reset pulse mid-frame.
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        line_tail(1);
        for (int b = 0; b < 4; b++) drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("swrst_busy", {31'd0, busy}, 32'd0);
        chk("swrst_line_count", {16'd0, line_count}, 32'd0);
        chk("swrst_frame_count", {16'd0, frame_count}, {16'd0, m_frame});
        chk("swrst_sof_err", {31'd0, sof_err}, 32'd0);
        cr_cycles = core_reset ? 1 : 0;
        for (int c = 0; c < 20 && core_reset; c++) begin
            tick();
            if (core_reset) cr_cycles++;
        end
        chk("swrst_core_reset_cycles", 32'(cr_cycles), 32'd4);
        tick();
        m_act  = 1'b0;
        m_line = 16'd0;
        m_mid  = 1'b0;
        m_err  = 1'b0;

        // Frame 6: mid-line SOF on line 0, then asynchronous reset.
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        drive_beat(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #3;
        aresetn = 1'b0;
        sw_en   = 1'b0;
        #1;
        chk("arst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_sof_err", {31'd0, sof_err}, 32'd0);
        chk("arst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("arst_line_count", {16'd0, line_count}, 32'd0);
        chk_coef(2, 32'd0);
        tick();
        aresetn = 1'b1;
        for (int c = 0; c < 5; c++) tick();

        // Zero lines-per-frame behaves as one line.
        cfg_write(4'd8, 32'd0);
        sw_en = 1'b1;
        tick();
        m_act   = 1'b0;
        m_line  = 16'd0;
        m_mid   = 1'b0;
        m_err   = 1'b0;
        m_frame = 16'd0;
        m_lpf   = 16'd1;
        drive_beat(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        line_tail(1);
        chk("lpf0_frame_count", {16'd0, frame_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
